// File: rtl/router_pkt_fifo_if.sv
// Handshake/data bundle between the router write side and the channel read port.
interface router_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 6
);
  logic                    write_enb;
  logic                    read_enb;
  logic                    lfd_state;
  logic [DATA_W-1:0]       data_in;
  logic [DATA_W-1:0]       data_out;
  logic                    data_valid;
  logic                    sop_out;
  logic                    eop_out;
  logic                    empty;
  logic                    full;
  logic                    almost_full;
  logic [$clog2(DEPTH):0]  level;
  logic [LEN_W:0]          pkt_remaining;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, data_valid, sop_out, eop_out, empty, full, almost_full,
           level, pkt_remaining
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, data_valid, sop_out, eop_out, empty, full, almost_full,
           level, pkt_remaining
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Parametrised router channel FIFO with header tagging, occupancy level and
// read-side packet length tracking (sop/eop markers).
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = 2,
  parameter int LEN_W     = 6,
  parameter int AF_THRESH = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  router_pkt_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = 1;
  localparam logic [AW:0]    AF_L    = AF_THRESH[AW:0];
  localparam logic [LEN_W:0] PKT_ONE = 1;

  typedef struct packed {
    logic              hdr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, level_q;
  logic [LEN_W:0]    pkt_q;
  logic              lfd_q;
  logic              push, pop;
  entry_t            rd_ent;
  logic [LEN_W-1:0]  rd_len;

  // MSB differs with equal index -> writer has lapped the reader
  assign bus.full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.almost_full   = (level_q >= AF_L);
  assign bus.level         = level_q;
  assign bus.pkt_remaining = pkt_q;

  assign push   = bus.write_enb && !bus.full;
  assign pop    = bus.read_enb && !bus.empty;
  assign rd_ent = mem[rd_ptr[AW-1:0]];
  assign rd_len = rd_ent.data[LEN_LSB +: LEN_W];

  always_ff @(posedge clk) begin
    if (resetn && !soft_reset && push)
      mem[wr_ptr[AW-1:0]] <= '{hdr: lfd_q, data: bus.data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      pkt_q          <= '0;
      lfd_q          <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.sop_out    <= 1'b0;
      bus.eop_out    <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_q        <= '0;
      pkt_q          <= '0;
      lfd_q          <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.sop_out    <= 1'b0;
      bus.eop_out    <= 1'b0;
    end else begin
      lfd_q          <= bus.lfd_state;
      bus.data_valid <= pop;
      bus.sop_out    <= 1'b0;
      bus.eop_out    <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
      if (pop) begin
        bus.data_out <= rd_ent.data;
        bus.sop_out  <= rd_ent.hdr;
        // header reloads even mid-packet; count covers payload plus parity
        if (rd_ent.hdr) begin
          pkt_q <= {1'b0, rd_len} + PKT_ONE;
        end else if (pkt_q != '0) begin
          pkt_q       <= pkt_q - PKT_ONE;
          bus.eop_out <= (pkt_q == PKT_ONE);
        end else begin
          bus.eop_out <= 1'b1;
        end
      end
    end
  end
endmodule
